// File: rtl/pe_io_pkg.sv
// Shared constants and FSM encoding for the PE I/O line server.
package pe_io_pkg;

   localparam int unsigned LINE_W_DEF = 512;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } state_e;

endpackage

// File: rtl/pe_io_server_if.sv
// Line handshake bundle between a PE/host pair and the pe_io_server.
interface pe_io_server_if import pe_io_pkg::*; #(
   parameter int unsigned LINE_W = LINE_W_DEF
);

   logic              available_read;
   logic [LINE_W-1:0] data_in;
   logic              req_rd_data;
   logic              available_write;
   logic [LINE_W-1:0] data_out;
   logic              req_wr_data;
   logic              host_in_valid;
   logic [LINE_W-1:0] host_in_data;
   logic              host_in_ready;
   logic              host_out_valid;
   logic [LINE_W-1:0] host_out_data;
   logic              host_out_ready;

   modport slave (
      output available_read, data_in, available_write, host_in_ready, host_out_valid,
             host_out_data,
      input  req_rd_data, data_out, req_wr_data, host_in_valid, host_in_data, host_out_ready
   );

   modport master (
      input  available_read, data_in, available_write, host_in_ready, host_out_valid,
             host_out_data,
      output req_rd_data, data_out, req_wr_data, host_in_valid, host_in_data, host_out_ready
   );

endinterface

// File: rtl/line_fifo.sv
// Show-ahead line FIFO; full/empty come from the registered count only.
module line_fifo #(
   parameter int unsigned Width = 512,
   parameter int unsigned Depth = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             push_refused_o,
   output logic             pop_ignored_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] CntFull = CntW'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   assign full_o         = (cnt_q == CntFull);
   assign empty_o        = (cnt_q == '0);
   assign push_ok        = push_i & ~full_o;
   assign pop_ok         = pop_i & ~empty_o;
   assign push_refused_o = push_i & full_o;
   assign pop_ignored_o  = pop_i & empty_o;
   // Stale storage is masked so the head reads zero whenever nothing is queued.
   assign rdata_o        = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = wdata_i;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/pe_io_server.sv
// Memory-side responder for one I/O PE: two line FIFOs, run FSM, line counters, error flags.
module pe_io_server import pe_io_pkg::*; #(
   parameter int unsigned LINE_W = LINE_W_DEF,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [31:0]         num_lines_in,
   input  logic [31:0]         num_lines_out,
   pe_io_server_if.slave       bus,
   output logic                run_done,
   output logic                err_underflow,
   output logic                err_overflow
);

   state_e      state_q, state_d;
   logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
   logic [31:0] n_in_q, n_in_d, n_out_q, n_out_d;
   logic        err_under_q, err_under_d, err_over_q, err_over_d;
   logic        start_ok;
   logic        rd_full, rd_empty, rd_pop_ignored, rd_push_refused;
   logic        wr_full, wr_empty, wr_push_refused, wr_pop_ignored;
   logic        unused_flags;

   line_fifo #(.Width(LINE_W), .Depth(DEPTH)) u_rd_fifo (
      .clk_i          (clk),
      .rst_ni         (rst),
      .push_i         (bus.host_in_valid),
      .wdata_i        (bus.host_in_data),
      .pop_i          (bus.req_rd_data),
      .rdata_o        (bus.data_in),
      .full_o         (rd_full),
      .empty_o        (rd_empty),
      .push_refused_o (rd_push_refused),
      .pop_ignored_o  (rd_pop_ignored)
   );

   line_fifo #(.Width(LINE_W), .Depth(DEPTH)) u_wr_fifo (
      .clk_i          (clk),
      .rst_ni         (rst),
      .push_i         (bus.req_wr_data),
      .wdata_i        (bus.data_out),
      .pop_i          (bus.host_out_ready),
      .rdata_o        (bus.host_out_data),
      .full_o         (wr_full),
      .empty_o        (wr_empty),
      .push_refused_o (wr_push_refused),
      .pop_ignored_o  (wr_pop_ignored)
   );

   assign bus.available_read  = ~rd_empty;
   assign bus.host_in_ready   = ~rd_full;
   assign bus.available_write = ~wr_full;
   assign bus.host_out_valid  = ~wr_empty;
   // Host-side backpressure on either FIFO is normal flow control, not an error.
   assign unused_flags        = ^{rd_push_refused, wr_pop_ignored};

   assign start_ok      = start & ((state_q == StIdle) | (state_q == StDone));
   assign run_done      = (state_q == StDone);
   assign err_underflow = err_under_q;
   assign err_overflow  = err_over_q;

   always_comb begin
      state_d     = state_q;
      rd_cnt_d    = rd_cnt_q;
      wr_cnt_d    = wr_cnt_q;
      n_in_d      = n_in_q;
      n_out_d     = n_out_q;
      err_under_d = err_under_q | rd_pop_ignored;
      err_over_d  = err_over_q | wr_push_refused;

      case (state_q)
         StIdle, StDone: if (start) state_d = StRun;
         StRun:   if ((rd_cnt_q == n_in_q) && (wr_cnt_q == n_out_q)) state_d = StDrain;
         StDrain: if (wr_empty) state_d = StDone;
         default: state_d = StIdle;
      endcase

      if (start_ok) begin
         rd_cnt_d    = '0;
         wr_cnt_d    = '0;
         n_in_d      = num_lines_in;
         n_out_d     = num_lines_out;
         err_under_d = 1'b0;
         err_over_d  = 1'b0;
      end else begin
         // Counters saturate at the expected totals; surplus traffic is still served.
         if (bus.req_rd_data && !rd_empty && (rd_cnt_q != n_in_q)) rd_cnt_d = rd_cnt_q + 1'b1;
         if (bus.req_wr_data && !wr_full && (wr_cnt_q != n_out_q)) wr_cnt_d = wr_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         rd_cnt_q    <= '0;
         wr_cnt_q    <= '0;
         n_in_q      <= '0;
         n_out_q     <= '0;
         err_under_q <= 1'b0;
         err_over_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_cnt_q    <= rd_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
         n_in_q      <= n_in_d;
         n_out_q     <= n_out_d;
         err_under_q <= err_under_d;
         err_over_q  <= err_over_d;
      end
   end

endmodule

// File: tb/tb_pe_io_server.sv
// Directed and randomized bench for pe_io_server against a queue-based run model.
module tb_pe_io_server;
   import pe_io_pkg::*;

   localparam int unsigned LINE_W = LINE_W_DEF;
   localparam int unsigned DEPTH  = 8;
   typedef logic [LINE_W-1:0] line_t;

   localparam int PhIdle = 0, PhRun = 1, PhDrain = 2, PhDone = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] num_lines_in = '0, num_lines_out = '0;
   logic        run_done, err_underflow, err_overflow;

   pe_io_server_if #(.LINE_W(LINE_W)) bus ();

   pe_io_server #(.LINE_W(LINE_W), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .num_lines_in  (num_lines_in),
      .num_lines_out (num_lines_out),
      .bus           (bus.slave),
      .run_done      (run_done),
      .err_underflow (err_underflow),
      .err_overflow  (err_overflow)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: FIFO contents as queues, run phase, line tallies and sticky errors.
   line_t       rq[$];
   line_t       wq[$];
   int          m_phase = PhIdle;
   int unsigned m_rd = 0, m_wr = 0, m_nin = 0, m_nout = 0;
   bit          m_eu = 0, m_eo = 0;

   task automatic chk(input string tag, input line_t obs, input line_t exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic line_t rand_line();
      line_t l;
      for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom();
      return l;
   endfunction

   task automatic model_reset();
      rq.delete();
      wq.delete();
      m_phase = PhIdle;
      m_rd = 0; m_wr = 0; m_nin = 0; m_nout = 0;
      m_eu = 0; m_eo = 0;
   endtask

   task automatic model_edge();
      int unsigned rsz = rq.size();
      int unsigned wsz = wq.size();
      bit rpop  = bus.req_rd_data && rsz > 0;
      bit rpush = bus.host_in_valid && rsz < DEPTH;
      bit wpush = bus.req_wr_data && wsz < DEPTH;
      bit wpop  = bus.host_out_ready && wsz > 0;
      bit sok   = start && (m_phase == PhIdle || m_phase == PhDone);
      int nxt   = m_phase;
      if (m_phase == PhIdle || m_phase == PhDone) begin
         if (start) nxt = PhRun;
      end else if (m_phase == PhRun) begin
         if (m_rd == m_nin && m_wr == m_nout) nxt = PhDrain;
      end else if (wsz == 0) begin
         nxt = PhDone;
      end
      if (sok) begin
         m_rd = 0; m_wr = 0; m_nin = num_lines_in; m_nout = num_lines_out;
         m_eu = 0; m_eo = 0;
      end else begin
         if (rpop && m_rd < m_nin) m_rd++;
         if (wpush && m_wr < m_nout) m_wr++;
         if (bus.req_rd_data && rsz == 0) m_eu = 1;
         if (bus.req_wr_data && wsz == DEPTH) m_eo = 1;
      end
      m_phase = nxt;
      if (rpop) void'(rq.pop_front());
      if (rpush) rq.push_back(bus.host_in_data);
      if (wpop) void'(wq.pop_front());
      if (wpush) wq.push_back(bus.data_out);
   endtask

   task automatic check_all();
      chk("available_read", line_t'(bus.available_read), line_t'(rq.size() != 0));
      chk("data_in", bus.data_in, (rq.size() != 0) ? rq[0] : '0);
      chk("host_in_ready", line_t'(bus.host_in_ready), line_t'(rq.size() < DEPTH));
      chk("available_write", line_t'(bus.available_write), line_t'(wq.size() < DEPTH));
      chk("host_out_valid", line_t'(bus.host_out_valid), line_t'(wq.size() != 0));
      chk("host_out_data", bus.host_out_data, (wq.size() != 0) ? wq[0] : '0);
      chk("run_done", line_t'(run_done), line_t'(m_phase == PhDone));
      chk("err_underflow", line_t'(err_underflow), line_t'(m_eu));
      chk("err_overflow", line_t'(err_overflow), line_t'(m_eo));
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_available_read"}, line_t'(bus.available_read), '0);
      chk({tag, "_data_in"}, bus.data_in, '0);
      chk({tag, "_host_in_ready"}, line_t'(bus.host_in_ready), line_t'(1));
      chk({tag, "_available_write"}, line_t'(bus.available_write), line_t'(1));
      chk({tag, "_host_out_valid"}, line_t'(bus.host_out_valid), '0);
      chk({tag, "_host_out_data"}, bus.host_out_data, '0);
      chk({tag, "_run_done"}, line_t'(run_done), '0);
      chk({tag, "_err_underflow"}, line_t'(err_underflow), '0);
      chk({tag, "_err_overflow"}, line_t'(err_overflow), '0);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      start = 0;
      bus.req_rd_data = 0; bus.req_wr_data = 0; bus.data_out = '0;
      bus.host_in_valid = 0; bus.host_in_data = '0; bus.host_out_ready = 0;
   endtask

   initial begin
      line_t pat;
      idle_inputs();
      #2;
      check_reset_values("por");
      #10 rst = 1;
      cycle();

      // Preload A, B, C in IDLE; read them back in a 3-line run.
      bus.host_in_valid = 1;
      pat = {128{4'hA}}; bus.host_in_data = pat; cycle();
      pat = {128{4'hB}}; bus.host_in_data = pat; cycle();
      pat = {128{4'hC}}; bus.host_in_data = pat; cycle();
      bus.host_in_valid = 0;
      start = 1; num_lines_in = 3; num_lines_out = 0; cycle();
      start = 0;
      bus.req_rd_data = 1;
      for (int i = 0; i < 3; i++) cycle();
      bus.req_rd_data = 0;
      cycle();
      chk("run_done_early", line_t'(run_done), '0);
      cycle();
      chk("run_done_after_pops", line_t'(run_done), line_t'(1));

      // Underflow, then cleared by a zero-length run.
      bus.req_rd_data = 1; cycle(); bus.req_rd_data = 0;
      chk("underflow_set", line_t'(err_underflow), line_t'(1));
      chk("underflow_no_avail", line_t'(bus.available_read), '0);
      start = 1; num_lines_in = 0; num_lines_out = 0; cycle(); start = 0;
      chk("underflow_cleared", line_t'(err_underflow), '0);
      cycle(); cycle();
      chk("zero_run_done", line_t'(run_done), line_t'(1));

      // Fill the write FIFO with the host stalled, overflow once, then drain.
      bus.req_wr_data = 1;
      for (int i = 0; i < DEPTH + 1; i++) begin
         bus.data_out = rand_line();
         cycle();
      end
      bus.req_wr_data = 0;
      chk("overflow_set", line_t'(err_overflow), line_t'(1));
      chk("write_full", line_t'(bus.available_write), '0);
      bus.host_out_ready = 1;
      for (int i = 0; i < DEPTH; i++) cycle();
      chk("write_drained", line_t'(bus.host_out_valid), '0);
      bus.host_out_ready = 0;

      // Simultaneous push/pop on the read FIFO at count 4.
      bus.host_in_valid = 1;
      for (int i = 0; i < 4; i++) begin
         bus.host_in_data = rand_line();
         cycle();
      end
      bus.host_in_data = rand_line(); bus.req_rd_data = 1; cycle();
      bus.host_in_valid = 0;
      for (int i = 0; i < 4; i++) cycle();
      bus.req_rd_data = 0;
      cycle();

      // Two output lines held back by the host keep the run in drain.
      start = 1; num_lines_in = 0; num_lines_out = 2; cycle(); start = 0;
      bus.req_wr_data = 1;
      for (int i = 0; i < 2; i++) begin
         bus.data_out = rand_line();
         cycle();
      end
      bus.req_wr_data = 0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("drain_hold", line_t'(run_done), '0);
      end
      bus.host_out_ready = 1;
      for (int i = 0; i < 4; i++) cycle();
      chk("drain_done", line_t'(run_done), line_t'(1));

      // Randomized traffic and runs.
      for (int i = 0; i < 600; i++) begin
         start = ($urandom_range(0, 29) == 0);
         num_lines_in = $urandom_range(0, 6);
         num_lines_out = $urandom_range(0, 6);
         bus.host_in_valid = $urandom_range(0, 1);
         bus.host_in_data = rand_line();
         bus.req_rd_data = ($urandom_range(0, 2) != 0);
         bus.req_wr_data = ($urandom_range(0, 2) != 0);
         bus.data_out = rand_line();
         bus.host_out_ready = ($urandom_range(0, 2) == 0);
         cycle();
      end

      // Mid-run reset with both FIFOs partly filled.
      idle_inputs();
      cycle();
      while (m_phase == PhRun || m_phase == PhDrain) begin
         bus.host_out_ready = 1; bus.req_rd_data = 1;
         num_lines_in = 0; num_lines_out = 0;
         cycle();
         if (n_tests > 200000) break;
      end
      idle_inputs();
      start = 1; num_lines_in = 9; num_lines_out = 9; cycle(); start = 0;
      while (rq.size() > 0) begin bus.req_rd_data = 1; cycle(); end
      bus.req_rd_data = 0;
      bus.host_in_valid = 1; bus.req_wr_data = 1;
      for (int i = 0; i < 4; i++) begin
         bus.host_in_data = rand_line(); bus.data_out = rand_line();
         cycle();
      end
      idle_inputs();
      rst = 0;
      #1;
      check_reset_values("midrun");
      model_reset();
      #2 rst = 1;
      for (int i = 0; i < 3; i++) cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
